// File: rtl/spm_seq.sv
`default_nettype none
// ============================================================================
// Module  : spm_seq
// Brief   : Operand sequencer and product deserialiser for the SPM multiplier.
// Revision: 1.0
// ============================================================================
module spm_seq #(
    parameter int N       = 8,
    parameter int SPM_LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           spm_clr,
    output logic [N-1:0]   spm_x,
    output logic           spm_y,
    input  logic           spm_p
);

    localparam int CW = $clog2(2*N + SPM_LAT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(2*N + SPM_LAT - 1);
    localparam logic [CW-1:0] C_LAT  = CW'(SPM_LAT);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [N-1:0]   mul_q,   mul_d;
    logic [N-1:0]   x_q,     x_d;
    logic [2*N-1:0] cap_q,   cap_d;
    logic [2*N-1:0] prod_q,  prod_d;
    logic           done_q,  done_d;

    logic           cap_en;
    logic [2*N-1:0] cap_shift;

    // Product bits arrive LSB first, so new bits enter at the top and the
    // register shifts right; after 2N captures bit 0 is the first sample.
    assign cap_shift = {spm_p, cap_q[2*N-1:1]};

    // Samples taken before the SPM pipeline has produced bit 0 are discarded.
    if (SPM_LAT == 0) begin : g_nolat
        assign cap_en = 1'b1;
    end else begin : g_lat
        assign cap_en = (cnt_q >= C_LAT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mul_q   <= '0;
            x_q     <= '0;
            cap_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            x_q     <= x_d;
            cap_q   <= cap_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        x_d     = x_q;
        cap_d   = cap_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = a;
                    mul_d   = b;
                    cap_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                mul_d = mul_q >> 1;
                cnt_d = cnt_q + C_ONE;
                if (cap_en) begin
                    cap_d = cap_shift;
                end
                if (cnt_q == C_LAST) begin
                    prod_d  = cap_shift;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign product = prod_q;
    assign spm_clr = (state_q == ST_CLEAR);
    assign spm_x   = x_q;
    // Multiplier register zero-fills, so bits past N are naturally 0.
    assign spm_y   = (state_q == ST_SHIFT) & mul_q[0];

endmodule
`default_nettype wire

// File: tb/tb_spm_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_spm_seq
// Brief   : Self-checking bench for spm_seq paired with arithmetic SPM models.
// Revision: 1.0
// ============================================================================
module tb_spm_seq;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   a = '0, b = '0;
    logic           start0 = 1'b0, start1 = 1'b0;
    logic           busy0, done0, clr0, y0, p0;
    logic           busy1, done1, clr1, y1, p1;
    logic [2*N-1:0] prod0, prod1;
    logic [N-1:0]   x0, x1;

    spm_seq #(.N(N), .SPM_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(prod0),
        .spm_clr(clr0), .spm_x(x0), .spm_y(y0), .spm_p(p0)
    );

    spm_seq #(.N(N), .SPM_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(prod1),
        .spm_clr(clr1), .spm_x(x1), .spm_y(y1), .spm_p(p1)
    );

    // SPM behaviour: p bit k is bit k of x * (multiplier bits seen so far).
    function automatic logic spm_bit(input logic [63:0] acc, input logic [N-1:0] x,
                                     input logic y, input int unsigned k);
        logic [63:0] s;
        s = acc + (y ? (64'(x) << k) : 64'd0);
        return s[k];
    endfunction

    logic [63:0] acc0 = '0, acc1 = '0;
    int unsigned k0 = 0, k1 = 0;
    logic        raw1, dly1a = 1'b0, dly1b = 1'b0;

    always @(posedge clk) begin
        if (clr0) begin
            acc0 <= '0;
            k0   <= 0;
        end else begin
            acc0 <= acc0 + (y0 ? (64'(x0) << k0) : 64'd0);
            k0   <= (k0 < 60) ? k0 + 1 : k0;
        end
        if (clr1) begin
            acc1 <= '0;
            k1   <= 0;
        end else begin
            acc1 <= acc1 + (y1 ? (64'(x1) << k1) : 64'd0);
            k1   <= (k1 < 60) ? k1 + 1 : k1;
        end
        dly1a <= raw1;
        dly1b <= dly1a;
    end

    assign p0   = spm_bit(acc0, x0, y0, k0);
    assign raw1 = spm_bit(acc1, x1, y1, k1);
    assign p1   = dly1b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Issue one start pulse and follow the operation to its done pulse.
    task automatic do_op(input bit sel, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic [15:0] exp, input string nm, input bit scramble);
        int n, clrs, dn, lat;
        lat = sel ? 2*N + 2 + 1 : 2*N + 0 + 1;
        @(negedge clk);
        a = ta; b = tbv;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        chk({nm, " clr"},  sel ? clr1 : clr0, 1);
        chk({nm, " busy"}, sel ? busy1 : busy0, 1);
        chk({nm, " x"},    sel ? x1 : x0, ta);
        n = 0; clrs = 0; dn = 0;
        while (n < 60 && dn == 0) begin
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(negedge clk);
            n++;
            if (sel ? clr1 : clr0) clrs++;
            if (sel ? done1 : done0) dn++;
        end
        chk({nm, " latency"}, n, lat);
        chk({nm, " product"}, sel ? prod1 : prod0, exp);
        chk({nm, " extra clr"}, clrs, 0);
        @(negedge clk);
        chk({nm, " done width"}, sel ? done1 : done0, 0);
        chk({nm, " idle"}, sel ? busy1 : busy0, 0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int dn, dcyc, got, last;
        logic [15:0] pr;
        logic [15:0] b2b_exp[4];

        vecs[0] = '{8'd12,  8'd13,  16'h009C};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd1,   8'd1,   16'h0001};
        for (int i = 4; i < 12; i++) begin
            vecs[i].a = 8'($urandom);
            vecs[i].b = 8'($urandom);
            vecs[i].p = ref_mul(vecs[i].a, vecs[i].b);
        end

        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst product", prod0, 0);
        chk("rst clr", clr0, 0);
        chk("rst x", x0, 0);
        chk("rst y", y0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle busy", busy0, 0);

        for (int i = 0; i < 12; i++) begin
            do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), (i % 2) == 1);
        end

        // Start pulsed five cycles into a running op must be ignored.
        @(negedge clk);
        a = 8'd12; b = 8'd13; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dn = 0; dcyc = 0; pr = '0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin a = 8'd3; b = 8'd3; start0 = 1'b1; end
            if (i == 6) start0 = 1'b0;
            @(negedge clk);
            if (done0) begin
                dn++;
                if (dn == 1) begin dcyc = i; pr = prod0; end
            end
        end
        chk("ignore done count", dn, 1);
        chk("ignore latency", dcyc, 17);
        chk("ignore product", pr, 16'h009C);
        chk("ignore idle", busy0, 0);

        // Reset in the middle of an op aborts it without a done pulse.
        @(negedge clk);
        a = 8'd12; b = 8'd13; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dn = 0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (done0) dn++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort busy", busy0, 0);
        chk("abort product", prod0, 0);
        chk("abort done", done0, 0);
        chk("abort clr", clr0, 0);
        chk("abort x", x0, 0);
        chk("abort y", y0, 0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done0) dn++;
        end
        chk("abort no done", dn, 0);
        do_op(1'b0, 8'd7, 8'd9, 16'h003F, "after abort", 1'b0);

        // Back-to-back: start held high, operands swapped at each done.
        // A new op is accepted on the edge ending the done cycle and takes
        // 17 further edges, so dones are 18 cycles apart with no idle gap.
        b2b_exp[0] = 16'h009C; b2b_exp[1] = 16'h003F;
        b2b_exp[2] = 16'h009C; b2b_exp[3] = 16'h003F;
        @(negedge clk);
        a = 8'd12; b = 8'd13; start0 = 1'b1;
        got = 0; last = 0;
        for (int i = 1; i <= 120 && got < 4; i++) begin
            @(negedge clk);
            if (done0) begin
                chk($sformatf("b2b product%0d", got), prod0, b2b_exp[got]);
                if (got > 0) chk($sformatf("b2b spacing%0d", got), i - last, 2*N + 2);
                last = i;
                got++;
                if (got == 4) start0 = 1'b0;
                else if (got % 2 == 1) begin a = 8'd7; b = 8'd9; end
                else begin a = 8'd12; b = 8'd13; end
            end
        end
        start0 = 1'b0;
        chk("b2b count", got, 4);
        @(negedge clk);
        chk("b2b idle", busy0, 0);

        // Two-cycle SPM pipeline latency.
        do_op(1'b1, 8'd12, 8'd13, 16'h009C, "lat2", 1'b0);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(1'b1, ra, rb, ref_mul(ra, rb), $sformatf("lat2 rnd%0d", i), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
